// File: rtl/instfetch_arbiter.sv
// instfetch_arbiter
//   Shares one instruction-memory read port among N_REQ fetch requesters.
//   Requesters are arbitrated round-robin. The winner's address is registered
//   onto mem_addr (grant stage). On the next edge the combinational memory
//   output is registered onto rdata, and rvalid strobes the winner (return
//   stage). A request therefore reaches rvalid in exactly two edges.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   req       in   [N_REQ]        per-requester fetch request
//   req_addr  in   [N_REQ*ADDR_W] packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt       out  [N_REQ]        registered one-hot grant
//   mem_addr  out  [ADDR_W]       registered address to instruction memory
//   mem_data  in   [WORD_W]       combinational read data from instruction memory
//   rvalid    out  [N_REQ]        registered one-hot return strobe
//   rdata     out  [WORD_W]       returned instruction word, qualified by rvalid
//   busy      out  1              any grant or return in flight

`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INSTMEM_WORDSIZE
`define INSTMEM_WORDSIZE 32
`endif

module instfetch_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = `INSTMEM_ADDR_WIDTH,
  parameter int WORD_W = `INSTMEM_WORDSIZE
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [WORD_W-1:0]         mem_data,
  output logic [N_REQ-1:0]          rvalid,
  output logic [WORD_W-1:0]         rdata,
  output logic                      busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] rdata_q;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [N_REQ-1:0]  elig;
  logic              hi_found, lo_found, found;
  logic [PTR_W-1:0]  hi_win, lo_win, win;
  logic [ADDR_W-1:0] hi_addr, lo_addr, win_addr;

  // The current grant holder is masked so a requester that keeps req high
  // through its grant cycle is not fetched twice for the same request.
  assign elig = req & ~gnt_q;

  // Round-robin search split in two halves: indices at/above the pointer
  // (hi) take priority over the wrapped-around indices below it (lo).
  // Scanning downward lets the lowest qualifying index win in each half.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    hi_addr  = '0;
    lo_addr  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_found = 1'b1;
        lo_win   = PTR_W'(i);
        lo_addr  = req_addr[i*ADDR_W +: ADDR_W];
        if (PTR_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_win   = PTR_W'(i);
          hi_addr  = req_addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
    found    = hi_found | lo_found;
    win      = hi_found ? hi_win  : lo_win;
    win_addr = hi_found ? hi_addr : lo_addr;
  end

  always_comb begin
    gnt_d      = '0;
    mem_addr_d = mem_addr_q;
    ptr_d      = ptr_q;
    if (found) begin
      gnt_d      = N_REQ'(1) << win;
      mem_addr_d = win_addr;
      ptr_d      = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q      <= '0;
      rvalid_q   <= '0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      mem_addr_q <= mem_addr_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= gnt_q;
      // Only capture memory data for a real return so rdata stays stable
      // between strobes.
      if (|gnt_q) begin
        rdata_q <= mem_data;
      end
    end
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign mem_addr = mem_addr_q;
  assign rdata    = rdata_q;
  assign busy     = (|gnt_q) | (|rvalid_q);

endmodule
